// File: rtl/demux_4_1_reg.sv
// ---------------------------------------------------------------------------
// demux_4_1_reg
//
// Registered 1-to-4 demultiplexer. A single source word is steered to one of
// four destination channels. Each channel has a single-entry holding register
// with a valid/ready handshake, so a full channel never stalls the others.
//
// Optional feature macro: DEMUX_COUNT_EN
//   When defined, adds port xfer_count and four CNT_WIDTH-bit drain counters.
//   These counters wrap at all-ones. When undefined, the port and the counters
//   are absent, and the handshake behaves the same way.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   in_data     in   source word (DATA_WIDTH)
//   in_sel      in   destination channel index 0..3
//   in_valid    in   source word / in_sel valid this cycle
//   in_ready    out  block accepts the source word this cycle (combinational)
//   out_data0-3 out  channel holding-register contents (registered)
//   out_valid   out  bit k: channel k holds an undelivered word (registered)
//   out_ready   in   bit k: consumer k accepts out_data_k this cycle
//   xfer_count  out  (DEMUX_COUNT_EN only) channel k drain count in bits
//                    [k*CNT_WIDTH +: CNT_WIDTH]
// ---------------------------------------------------------------------------
module demux_4_1_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [1:0]              in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   out_data0,
    output logic [DATA_WIDTH-1:0]   out_data1,
    output logic [DATA_WIDTH-1:0]   out_data2,
    output logic [DATA_WIDTH-1:0]   out_data3,
    output logic [3:0]              out_valid,
    input  logic [3:0]              out_ready
`ifdef DEMUX_COUNT_EN
    ,
    output logic [4*CNT_WIDTH-1:0]  xfer_count
`endif
);

    // Per-channel holding registers and their valid bits.
    logic [DATA_WIDTH-1:0] data_r [4];
    logic [3:0]            valid_r;

    // Combinational handshake terms.
    logic [3:0] sel_onehot_s;
    logic       sel_busy_s;
    logic       in_ready_s;
    logic       accept_s;
    logic [3:0] drain_s;
    logic [3:0] load_s;
    logic [3:0] valid_nxt_s;

    // Decode the destination index into a one-hot channel mask.
    always_comb begin
        sel_onehot_s = 4'b0000;
        case (in_sel)
            2'd0:    sel_onehot_s = 4'b0001;
            2'd1:    sel_onehot_s = 4'b0010;
            2'd2:    sel_onehot_s = 4'b0100;
            2'd3:    sel_onehot_s = 4'b1000;
            default: sel_onehot_s = 4'b0000;
        endcase
    end

    // The selected channel is busy only if it holds a word that is not being
    // drained this cycle. The other channels do not affect readiness.
    always_comb begin
        sel_busy_s = 1'b0;
        case (in_sel)
            2'd0:    sel_busy_s = valid_r[0] & ~out_ready[0];
            2'd1:    sel_busy_s = valid_r[1] & ~out_ready[1];
            2'd2:    sel_busy_s = valid_r[2] & ~out_ready[2];
            2'd3:    sel_busy_s = valid_r[3] & ~out_ready[3];
            default: sel_busy_s = 1'b1;
        endcase
    end

    // Accept and load or drain qualifiers. A drain and a load on the same
    // channel in one cycle leave the channel FULL with the new word, so no
    // bubble appears.
    always_comb begin
        in_ready_s  = ~reset & ~sel_busy_s;
        accept_s    = in_valid & in_ready_s;
        drain_s     = valid_r & out_ready;
        load_s      = sel_onehot_s & {4{accept_s}};
        valid_nxt_s = (valid_r & ~drain_s) | load_s;
    end

    assign in_ready = in_ready_s;

    // Track the per-channel EMPTY/FULL state. Reset discards pending words.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 4'b0000;
        end else begin
            valid_r <= valid_nxt_s;
        end
    end

    // Holding registers change only on a load. This keeps data stable while
    // a word waits for its consumer, and it keeps the last word after a drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                data_r[k] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load_s[k]) begin
                    data_r[k] <= in_data;
                end else begin
                    data_r[k] <= data_r[k];
                end
            end
        end
    end

    assign out_data0 = data_r[0];
    assign out_data1 = data_r[1];
    assign out_data2 = data_r[2];
    assign out_data3 = data_r[3];
    assign out_valid = valid_r;

`ifdef DEMUX_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_r [4];

    // Count drains per channel. Loads do not count. The count wraps with no
    // saturation.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                cnt_r[k] <= {CNT_WIDTH{1'b0}};
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (drain_s[k]) begin
                    cnt_r[k] <= cnt_r[k] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    cnt_r[k] <= cnt_r[k];
                end
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_cnt_out
        assign xfer_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt_r[g];
    end
`endif

endmodule

// File: tb/tb_demux_4_1_reg.sv
// ---------------------------------------------------------------------------
// tb_demux_4_1_reg
//
// Self-checking bench for demux_4_1_reg. A behavioural model keeps four
// "mailboxes" (one valid flag, data word and drain tally per channel). The
// model updates them from the handshake rules and compares them with the DUT
// after every edge. It also compares the predicted in_ready before each edge.
// Directed steps follow the test plan. A randomized phase then runs.
// ---------------------------------------------------------------------------
module tb_demux_4_1_reg;

    localparam int DW = 32;
`ifdef DEMUX_COUNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic          clk;
    logic          reset;
    logic [DW-1:0] in_data;
    logic [1:0]    in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data0, out_data1, out_data2, out_data3;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
`ifdef DEMUX_COUNT_EN
    logic [4*CW-1:0] xfer_count;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state.
    bit            m_full [4];
    logic [DW-1:0] m_word [4];
    int            m_drains [4];

    demux_4_1_reg #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX_COUNT_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] dut_word(input int k);
        case (k)
            0:       return out_data0;
            1:       return out_data1;
            2:       return out_data2;
            default: return out_data3;
        endcase
    endfunction

    // Compare every registered output with the model.
    task automatic check_outputs();
        logic [3:0] mv;
        for (int k = 0; k < 4; k++) mv[k] = m_full[k];
        check("out_valid", {60'd0, out_valid}, {60'd0, mv});
        for (int k = 0; k < 4; k++) begin
            check($sformatf("out_data%0d", k), {32'd0, dut_word(k)}, {32'd0, m_word[k]});
`ifdef DEMUX_COUNT_EN
            check($sformatf("xfer_count%0d", k),
                  {{(64-CW){1'b0}}, xfer_count[k*CW +: CW]},
                  64'(m_drains[k] % (1 << CW)));
`endif
        end
    endtask

    // One clock cycle. Inputs are driven at the negedge. in_ready is compared
    // before the posedge, and the outputs are compared #1 after it.
    task automatic cycle(input bit rst, input bit iv, input logic [1:0] sel,
                         input logic [DW-1:0] d, input logic [3:0] ordy,
                         output bit took);
        bit exp_rdy;
        reset = rst; in_valid = iv; in_sel = sel; in_data = d; out_ready = ordy;
        #1;
        exp_rdy = !rst && (!m_full[sel] || ordy[sel]);
        check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        took = iv && in_ready;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                m_full[k] = 1'b0; m_word[k] = '0; m_drains[k] = 0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (m_full[k] && ordy[k]) begin
                    m_full[k] = 1'b0;
                    m_drains[k]++;
                end
            end
            if (iv && exp_rdy) begin
                m_full[sel] = 1'b1;
                m_word[sel] = d;
            end
        end
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    initial begin
        bit t;
        int accepts;
        for (int k = 0; k < 4; k++) begin
            m_full[k] = 1'b0; m_word[k] = '0; m_drains[k] = 0;
        end
        reset = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'b0000;
        @(negedge clk);

        // Hold reset for 2 cycles with in_valid high.
        cycle(1'b1, 1'b1, 2'd1, 32'h12345678, 4'b0000, t);
        cycle(1'b1, 1'b1, 2'd2, 32'h87654321, 4'b0000, t);
        check("reset_valid_const", {60'd0, out_valid}, 64'd0);

        // Single transfer to channel 2. The word is then held for 5 cycles.
        cycle(1'b0, 1'b1, 2'd2, 32'hDEADBEEF, 4'b0000, t);
        check("single_accept", {63'd0, t}, 64'd1);
        check("single_valid_const", {60'd0, out_valid}, 64'h4);
        check("single_data_const", {32'd0, out_data2}, 64'hDEADBEEF);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 2'd2, $urandom, 4'b0000, t);
        check("hold_data_const", {32'd0, out_data2}, 64'hDEADBEEF);
        cycle(1'b0, 1'b0, 2'd0, '0, 4'b0100, t);
        check("drain_valid_const", {60'd0, out_valid}, 64'd0);

        // Per-channel backpressure.
        cycle(1'b0, 1'b1, 2'd1, 32'h11111111, 4'b0000, t);
        cycle(1'b0, 1'b1, 2'd1, 32'hBAD0BAD0, 4'b0000, t);
        check("bp_reject", {63'd0, t}, 64'd0);
        check("bp_data1_const", {32'd0, out_data1}, 64'h11111111);
        cycle(1'b0, 1'b1, 2'd3, 32'h33333333, 4'b0000, t);
        check("bp_other_accept", {63'd0, t}, 64'd1);
        check("bp_valid_const", {60'd0, out_valid}, 64'hA);

        // Simultaneous drain and load on channel 0, then stream 8 words.
        cycle(1'b0, 1'b1, 2'd0, 32'h0000000A, 4'b0000, t);
        cycle(1'b0, 1'b1, 2'd0, 32'h0000000B, 4'b0001, t);
        check("dl_accept", {63'd0, t}, 64'd1);
        check("dl_data0_const", {32'd0, out_data0}, 64'hB);
        accepts = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 2'd0, 32'hC000_0000 + i, 4'b0001, t);
            if (t) accepts++;
        end
        check("stream_accepts", 64'(accepts), 64'd8);

        // Reset mid-operation, concurrent with an accept to channel 2.
        cycle(1'b0, 1'b1, 2'd3, 32'h3A3A3A3A, 4'b0000, t);
        cycle(1'b1, 1'b1, 2'd2, 32'h22222222, 4'b0000, t);
        check("midrst_valid_const", {60'd0, out_valid}, 64'd0);
        check("midrst_data2_const", {32'd0, out_data2}, 64'd0);

`ifdef DEMUX_COUNT_EN
        // 17 drains on channel 1 wrap the 4-bit counter to 1.
        for (int i = 0; i < 17; i++) begin
            cycle(1'b0, 1'b1, 2'd1, $urandom, 4'b0000, t);
            cycle(1'b0, 1'b0, 2'd0, '0, 4'b0010, t);
        end
        check("cnt_wrap_const", {48'd0, xfer_count}, 64'h0010);
        cycle(1'b0, 1'b1, 2'd3, $urandom, 4'b0000, t);
        check("cnt_load_only_const", {48'd0, xfer_count}, 64'h0010);
`endif

        // Randomized phase, with an occasional reset.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0), 1'(($urandom_range(0, 3) != 0)),
                  2'($urandom_range(0, 3)), $urandom, 4'($urandom), t);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog, so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
